ps2_move_decoder: RTL and testbench
===================================

// Module: ps2_move_decoder
// PURPOSE
//  Receives PS/2 keyboard frames. Decodes make/break scancodes into the 3-bit player
//  move codes (play1_M, play2_M) that the game top and step logic consume, plus a
//  start pulse for the start/pause debounce path. Replaces the board-switch move inputs.
//  Player 1 uses W/A/S/D. Player 2 uses the arrow keys. Space generates the start pulse.
// PARAMETERS
//  TIMEOUT_CYC  20'd200000  idle clk cycles allowed between PS/2 falling edges inside a frame
//  SYNC_STAGES  2           synchroniser depth on ps2_clk and ps2_data (minimum 2)
// PORTS
//  clk         in   1  system clock, 100 MHz
//  rst_n       in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw keyboard clock, asynchronous to clk
//  ps2_data    in   1  raw keyboard data, asynchronous to clk
//  play1_M     out  3  player 1 move code, registered
//  play2_M     out  3  player 2 move code, registered
//  start_key   out  1  one-clk pulse on each space make code; auto-repeat codes are ignored
//  frame_err   out  1  one-clk pulse on a parity, start-bit, stop-bit or timeout error
// BEHAVIOUR
//  Reset values: play1_M=0, play2_M=0, start_key=0, frame_err=0, held keys cleared,
//  receiver idle, decoder state IDLE.
//  Receiver
//   - Samples ps2_data on the synchronised falling edge of ps2_clk.
//   - Frame is 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
//   - byte_done pulses in the clk cycle the stop-bit edge is detected, and only when start,
//     parity and stop are all correct. Any failure: byte dropped, frame_err pulses that cycle.
//   - Timeout: bit count nonzero and no edge for TIMEOUT_CYC cycles -> abort, frame_err,
//     return to bit 0.
//  Decoder FSM (advances only on byte_done)
//   IDLE    -> E0 on 8'hE0; -> BRK on 8'hF0; else apply make(code,ext=0)
//   E0      -> E0BRK on 8'hF0; else apply make(code,ext=1), -> IDLE
//   BRK     -> apply break(code,ext=0), -> IDLE
//   E0BRK   -> apply break(code,ext=1), -> IDLE
//  Key map (sets/clears one bit of the 9-bit held register):
//   P1: W=1D up, S=1B down, A=1C left, D=23 right
//   P2: E0 75 up, E0 72 down, E0 6B left, E0 74 right
//   Space = 29, not extended
//  Unmapped codes do not change held state. Extended-ness must match: non-extended 75
//  (keypad 8) does nothing.
//  Move encoding: 0 none, 1 up, 2 down, 3 left, 4 right.
//   - Fixed priority up > down > left > right among keys held for that player.
//   - 5..7 never driven.
//  Latency: held register updates at byte_done+1; play*_M registered at byte_done+2.
//   start_key asserts at byte_done+1 for a space make when space was not already held.
//  Simultaneous: P1 and P2 state is independent. Release of a lower-priority key while a
//   higher one is held leaves the output unchanged.
//  Frame error inside a multi-byte sequence: decoder returns to IDLE and held state is kept.
//  Async reset mid-frame: everything returns to reset values; the next falling edge is
//   treated as bit 0.
// STRUCTURE
//  Shared game package holds:
//   - MOVE_NONE/UP/DOWN/LEFT/RIGHT (3-bit) constants, also used by step and AI
//   - scancode constants SC_E0, SC_F0, SC_W ... SC_SPACE
//  Sub-module ps2_rx: synchroniser, edge detect, bit shifter, parity, timeout.
//   Outputs byte_done, rx_byte, frame_err.
//  Top level: decoder FSM, held-key register, priority encoders.
// TESTING
//  1 Send 1D (W make) -> play1_M=1 at byte_done+2. Then F0 1D -> play1_M=0. play2_M stays 0.
//  2 Send E0 74, then E0 75 -> play2_M=4, then 1 (up beats right).
//    Then E0 F0 75 -> play2_M=4.
//  3 Send 75 non-extended -> play2_M unchanged at 0.
//    Send 1C with bad parity -> frame_err pulse once, play1_M stays 0.
//  4 Send 29, then 29 again (auto-repeat), then F0 29, then 29
//    -> exactly two start_key pulses, each 1 clk wide.
//  5 Send 5 data bits, then idle TIMEOUT_CYC+10 cycles -> frame_err once.
//    A following valid 1B decodes -> play1_M=2.
//  6 Hold 1D and E0 72, then pull rst_n low mid-frame
//    -> both outputs 0 immediately; after release the next 23 gives play1_M=4.

Source files
------------

// File: rtl/ps2_move_decoder_pkg.sv
// ps2_move_decoder_pkg: shared move codes, scancodes and key-map helpers for the game
package ps2_move_decoder_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_BRK, ST_E0BRK} dec_state_e;

   localparam logic [2:0] MOVE_NONE  = 3'd0;
   localparam logic [2:0] MOVE_UP    = 3'd1;
   localparam logic [2:0] MOVE_DOWN  = 3'd2;
   localparam logic [2:0] MOVE_LEFT  = 3'd3;
   localparam logic [2:0] MOVE_RIGHT = 3'd4;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_SPACE = 8'h29;

   // Held-register bit positions: [3:0] player 1 up/down/left/right, [7:4] player 2, [8] space
   localparam logic [3:0] KEY_SPACE = 4'd8;
   localparam logic [3:0] KEY_NONE  = 4'hF;

   // Maps a scancode plus its extended flag to a held-register bit; extended-ness must match
   function automatic logic [3:0] key_index(input logic [7:0] code, input logic ext);
      if (!ext) begin
         case (code)
            SC_W:     return 4'd0;
            SC_S:     return 4'd1;
            SC_A:     return 4'd2;
            SC_D:     return 4'd3;
            SC_SPACE: return KEY_SPACE;
            default:  return KEY_NONE;
         endcase
      end
      case (code)
         SC_UP:    return 4'd4;
         SC_DOWN:  return 4'd5;
         SC_LEFT:  return 4'd6;
         SC_RIGHT: return 4'd7;
         default:  return KEY_NONE;
      endcase
   endfunction

   // Fixed priority up > down > left > right over one player's four held bits
   function automatic logic [2:0] move_enc(input logic [3:0] h);
      return h[0] ? MOVE_UP : h[1] ? MOVE_DOWN : h[2] ? MOVE_LEFT : h[3] ? MOVE_RIGHT : MOVE_NONE;
   endfunction

endpackage

// File: rtl/ps2_move_decoder_rx.sv
// ps2_move_decoder_rx: PS/2 frame receiver with synchroniser, parity/framing check and timeout
module ps2_move_decoder_rx #(
   parameter logic [19:0] TIMEOUT_CYC = 20'd200000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_done,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
   logic                   clk_prev_q;
   logic [3:0]             cnt_q;
   logic [9:0]             sh_q;
   logic [19:0]            tmo_q;
   logic                   fall, din, last, ok, timeout;

   // sh_q holds start in [0], data in [8:1], parity in [9] once the stop-bit edge arrives
   always_comb begin
      fall      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      din       = dat_sync_q[SYNC_STAGES-1];
      last      = fall && cnt_q == 4'd10;
      ok        = ~sh_q[0] & din & (^sh_q[9:1]);
      timeout   = cnt_q != 4'd0 && !fall && tmo_q >= TIMEOUT_CYC;
      byte_done = last & ok;
      frame_err = (last & ~ok) | timeout;
      rx_byte   = sh_q[8:1];
   end

   // Lines idle high, so the synchronisers reset to 1 to avoid a false edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         clk_prev_q <= 1'b1;
         cnt_q      <= 4'd0;
         sh_q       <= '0;
         tmo_q      <= '0;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
         clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
         cnt_q      <= (last || timeout) ? 4'd0 : fall ? cnt_q + 4'd1 : cnt_q;
         sh_q       <= fall ? {din, sh_q[9:1]} : sh_q;
         tmo_q      <= (fall || cnt_q == 4'd0) ? 20'd0 : tmo_q + 20'd1;
      end
   end

endmodule

// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder: turns PS/2 make/break scancodes into per-player move codes and a start pulse
module ps2_move_decoder
   import ps2_move_decoder_pkg::*;
#(
   parameter logic [19:0] TIMEOUT_CYC = 20'd200000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [2:0] play1_M,
   output logic [2:0] play2_M,
   output logic       start_key,
   output logic       frame_err
);

   logic       byte_done;
   logic [7:0] rx_byte;
   dec_state_e state_q, state_d;
   logic [8:0] held_q, held_d;
   logic       start_q, start_d;
   logic [2:0] p1_q, p2_q;
   logic [3:0] idx;
   logic       mk, brk;

   ps2_move_decoder_rx #(.TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .byte_done (byte_done),
      .rx_byte   (rx_byte),
      .frame_err (frame_err)
   );

   // Prefix-tracking FSM; a frame error abandons any half-received sequence but keeps held keys
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      start_d = 1'b0;
      idx     = key_index(rx_byte, state_q == ST_E0 || state_q == ST_E0BRK);
      mk      = 1'b0;
      brk     = 1'b0;
      if (frame_err) begin
         state_d = ST_IDLE;
      end else if (byte_done) begin
         case (state_q)
            ST_IDLE: state_d = rx_byte == SC_E0 ? ST_E0 : rx_byte == SC_F0 ? ST_BRK : ST_IDLE;
            ST_E0:   state_d = rx_byte == SC_F0 ? ST_E0BRK : ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
         mk  = (state_q == ST_IDLE && rx_byte != SC_E0 && rx_byte != SC_F0) ||
               (state_q == ST_E0 && rx_byte != SC_F0);
         brk = state_q == ST_BRK || state_q == ST_E0BRK;
         if (idx != KEY_NONE && (mk || brk)) held_d[idx] = mk;
         start_d = mk && idx == KEY_SPACE && !held_q[KEY_SPACE];
      end
   end

   // State, held keys and start pulse update one cycle after byte_done; moves one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         held_q  <= '0;
         start_q <= 1'b0;
         p1_q    <= MOVE_NONE;
         p2_q    <= MOVE_NONE;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         start_q <= start_d;
         p1_q    <= move_enc(held_q[3:0]);
         p2_q    <= move_enc(held_q[7:4]);
      end
   end

   assign play1_M   = p1_q;
   assign play2_M   = p2_q;
   assign start_key = start_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb_ps2_move_decoder: directed and randomized key-event checks against a key-state model
module tb_ps2_move_decoder;

   localparam logic [19:0] TMO = 20'd1000;
   localparam int          HP  = 6;

   logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [2:0] play1_M, play2_M;
   logic       start_key, frame_err;
   int         total = 0, bad = 0, sk_cnt = 0, fe_cnt = 0;

   typedef struct {logic [7:0] code; bit ext; int pl; int dir;} key_t;
   key_t keys[12];
   bit   p1[4], p2[4];
   bit   sp;

   always #5 clk = ~clk;

   ps2_move_decoder #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .play1_M   (play1_M),
      .play2_M   (play2_M),
      .start_key (start_key),
      .frame_err (frame_err)
   );

   // Counts high cycles, so a pulse wider than one clock inflates the count
   always @(negedge clk) begin
      if (start_key) sk_cnt++;
      if (frame_err) fe_cnt++;
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par = 1'b0, input int n = 11);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         clks(HP);
         ps2_clk = 1'b0;
         clks(HP);
         ps2_clk = 1'b1;
      end
      clks(HP);
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int first_held(input bit h[4]);
      for (int d = 0; d < 4; d++) if (h[d]) return d + 1;
      return 0;
   endfunction

   initial begin
      int s0, f0, k, mk, es;
      keys[0]  = '{8'h1D, 1'b0, 1, 0};
      keys[1]  = '{8'h1B, 1'b0, 1, 1};
      keys[2]  = '{8'h1C, 1'b0, 1, 2};
      keys[3]  = '{8'h23, 1'b0, 1, 3};
      keys[4]  = '{8'h75, 1'b1, 2, 0};
      keys[5]  = '{8'h72, 1'b1, 2, 1};
      keys[6]  = '{8'h6B, 1'b1, 2, 2};
      keys[7]  = '{8'h74, 1'b1, 2, 3};
      keys[8]  = '{8'h29, 1'b0, 3, 0};
      keys[9]  = '{8'h75, 1'b0, 0, 0};
      keys[10] = '{8'h1D, 1'b1, 0, 0};
      keys[11] = '{8'h15, 1'b0, 0, 0};
      clks(3);
      chk("rst_p1", play1_M, 0);
      chk("rst_p2", play2_M, 0);
      chk("rst_sk", start_key, 0);
      chk("rst_fe", frame_err, 0);
      rst_n = 1'b1;
      clks(3);
      frame(8'h1D);
      chk("w_make_p1", play1_M, 1);
      frame(8'hF0); frame(8'h1D);
      chk("w_brk_p1", play1_M, 0);
      chk("w_brk_p2", play2_M, 0);
      frame(8'hE0); frame(8'h74);
      chk("right_p2", play2_M, 4);
      frame(8'hE0); frame(8'h75);
      chk("up_over_right", play2_M, 1);
      frame(8'hE0); frame(8'hF0); frame(8'h75);
      chk("up_rel_p2", play2_M, 4);
      frame(8'hE0); frame(8'hF0); frame(8'h74);
      chk("right_rel_p2", play2_M, 0);
      frame(8'h75);
      chk("nonext_75", play2_M, 0);
      f0 = fe_cnt;
      frame(8'h1C, 1'b1);
      chk("par_fe", fe_cnt - f0, 1);
      chk("par_p1", play1_M, 0);
      s0 = sk_cnt;
      frame(8'h29);
      chk("sp_first", sk_cnt - s0, 1);
      frame(8'h29);
      frame(8'hF0); frame(8'h29);
      frame(8'h29);
      chk("sp_pulses", sk_cnt - s0, 2);
      f0 = fe_cnt;
      frame(8'h1B, 1'b0, 6);
      clks(int'(TMO) + 10);
      chk("tmo_fe", fe_cnt - f0, 1);
      frame(8'h1B);
      chk("after_tmo_p1", play1_M, 2);
      frame(8'h1D); frame(8'hE0); frame(8'h72);
      chk("hold_p1", play1_M, 1);
      chk("hold_p2", play2_M, 2);
      frame(8'h23, 1'b0, 4);
      rst_n = 1'b0;
      #1;
      chk("arst_p1", play1_M, 0);
      chk("arst_p2", play2_M, 0);
      clks(3);
      rst_n = 1'b1;
      clks(2);
      frame(8'h23);
      chk("post_rst_p1", play1_M, 4);
      chk("post_rst_p2", play2_M, 0);
      rst_n = 1'b0;
      clks(2);
      rst_n = 1'b1;
      clks(2);
      for (int d = 0; d < 4; d++) begin
         p1[d] = 1'b0;
         p2[d] = 1'b0;
      end
      sp = 1'b0;
      for (int n = 0; n < 90; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            f0 = fe_cnt;
            frame($urandom_range(0, 1) ? 8'hE0 : 8'hF0);
            frame(8'($urandom), 1'b1);
            chk("rnd_garbage_fe", fe_cnt - f0, 1);
         end
         k  = $urandom_range(0, 11);
         mk = $urandom_range(0, 1);
         s0 = sk_cnt;
         es = (keys[k].pl == 3 && mk == 1 && !sp) ? 1 : 0;
         if (keys[k].ext) frame(8'hE0);
         if (mk == 0) frame(8'hF0);
         frame(keys[k].code);
         if (keys[k].pl == 1) p1[keys[k].dir] = mk[0];
         if (keys[k].pl == 2) p2[keys[k].dir] = mk[0];
         if (keys[k].pl == 3) sp = mk[0];
         chk("rnd_p1", play1_M, first_held(p1));
         chk("rnd_p2", play2_M, first_held(p2));
         chk("rnd_sk", sk_cnt - s0, es);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
